// File: rtl/soc_ifc_fuse_wr_tracker_if.sv
// SoC fuse-write request bus and forwarded fuse register-file write port.
// The master side is the SoC requester; the slave side is the tracker.
interface soc_ifc_fuse_wr_tracker_if #(
    parameter int ADDR_W = 8
);
    logic              soc_req_vld;
    logic [ADDR_W-1:0] soc_req_addr;
    logic [31:0]       soc_req_wdata;
    logic              fuse_we;
    logic [ADDR_W-1:0] fuse_wr_addr;
    logic [31:0]       fuse_wr_data;

    modport master (
        output soc_req_vld, soc_req_addr, soc_req_wdata,
        input  fuse_we, fuse_wr_addr, fuse_wr_data
    );

    modport slave (
        input  soc_req_vld, soc_req_addr, soc_req_wdata,
        output fuse_we, fuse_wr_addr, fuse_wr_data
    );
endinterface

// File: rtl/soc_ifc_fuse_wr_tracker.sv
// Gates SoC fuse writes, tracks written words, issues the one-shot fuse_done set.
// Define SOC_IFC_FUSE_WR_STRICT_EN to require every fuse word written before fuse_done is accepted.
//
// state     | meaning
// FT_WAIT   | boot FSM not in fuse-load; fuse and done writes rejected
// FT_OPEN   | fuse words forwarded and tracked; done write locks
// FT_LOCKED | fuse_done set (now or before warm reset); fuse writes rejected
module soc_ifc_fuse_wr_tracker #(
    parameter int NUM_FUSE_WORDS = 64,
    parameter int ADDR_W         = 8,
    parameter int FUSE_DONE_ADDR = NUM_FUSE_WORDS,
    localparam int CNT_W         = $clog2(NUM_FUSE_WORDS + 1)
) (
    input  logic             clk,
    input  logic             cptra_rst,
    input  logic             ready_for_fuses,
    input  logic             fuse_done_reg,
    soc_ifc_fuse_wr_tracker_if.slave bus,
    output logic             fuse_done_set,
    output logic             fuse_wr_done_observed,
    output logic             fuse_wr_err,
    output logic [CNT_W-1:0] fuse_wr_count
);

    localparam int IDX_W = (NUM_FUSE_WORDS > 1) ? $clog2(NUM_FUSE_WORDS) : 1;
    localparam logic [ADDR_W-1:0] NUM_WORDS_A = ADDR_W'(NUM_FUSE_WORDS);
    localparam logic [ADDR_W-1:0] DONE_A      = ADDR_W'(FUSE_DONE_ADDR);

    typedef enum logic [1:0] {
        FT_WAIT   = 2'd0,
        FT_OPEN   = 2'd1,
        FT_LOCKED = 2'd2
    } ft_state_e;

    ft_state_e                 state, state_nxt;
    logic [NUM_FUSE_WORDS-1:0] bitmap, bitmap_nxt;
    logic [CNT_W-1:0]          count, count_nxt;
    logic                      we_q, we_nxt;
    logic [ADDR_W-1:0]         addr_q, addr_nxt;
    logic [31:0]               data_q, data_nxt;
    logic                      set_q, set_nxt;
    logic                      obs_q, obs_nxt;
    logic                      err_q, err_nxt;

    logic             is_word, is_done, is_other, done_req;
    logic [IDX_W-1:0] idx;

    assign is_word  = bus.soc_req_vld && (bus.soc_req_addr < NUM_WORDS_A);
    assign is_done  = bus.soc_req_vld && (bus.soc_req_addr == DONE_A);
    assign is_other = bus.soc_req_vld && !is_word && !is_done;
    assign done_req = is_done && bus.soc_req_wdata[0];
    assign idx      = bus.soc_req_addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (cptra_rst) begin
            state  <= FT_WAIT;
            bitmap <= '0;
            count  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            set_q  <= 1'b0;
            obs_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            bitmap <= bitmap_nxt;
            count  <= count_nxt;
            we_q   <= we_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
            set_q  <= set_nxt;
            obs_q  <= obs_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        bitmap_nxt = bitmap;
        count_nxt  = count;
        we_nxt     = 1'b0;
        addr_nxt   = addr_q;
        data_nxt   = data_q;
        set_nxt    = 1'b0;
        obs_nxt    = obs_q;
        err_nxt    = 1'b0;

        unique case (state)
            FT_WAIT: begin
                if (is_word || is_done) err_nxt = 1'b1;
                if (ready_for_fuses) state_nxt = fuse_done_reg ? FT_LOCKED : FT_OPEN;
            end
            FT_OPEN: begin
                if (!ready_for_fuses) state_nxt = FT_WAIT;
                if (is_word) begin
                    we_nxt   = 1'b1;
                    addr_nxt = bus.soc_req_addr;
                    data_nxt = bus.soc_req_wdata;
                    // Count only first writes, so the count cannot exceed NUM_FUSE_WORDS.
                    if (!bitmap[idx]) begin
                        bitmap_nxt[idx] = 1'b1;
                        count_nxt       = count + CNT_W'(1);
                    end
                end else if (done_req) begin
`ifdef SOC_IFC_FUSE_WR_STRICT_EN
                    if (&bitmap) begin
                        set_nxt   = 1'b1;
                        obs_nxt   = 1'b1;
                        state_nxt = FT_LOCKED;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = FT_OPEN;
                    end
`else
                    set_nxt   = 1'b1;
                    obs_nxt   = 1'b1;
                    state_nxt = FT_LOCKED;
`endif
                end
            end
            FT_LOCKED: begin
                if (is_word) err_nxt = 1'b1;
                else if (done_req) obs_nxt = 1'b1;
            end
            default: state_nxt = FT_WAIT;
        endcase

        if (is_other) err_nxt = 1'b1;
    end

    assign bus.fuse_we           = we_q;
    assign bus.fuse_wr_addr      = addr_q;
    assign bus.fuse_wr_data      = data_q;
    assign fuse_done_set         = set_q;
    assign fuse_wr_done_observed = obs_q;
    assign fuse_wr_err           = err_q;
    assign fuse_wr_count         = count;

endmodule

// File: tb/tb_soc_ifc_fuse_wr_tracker.sv
// Directed self-checking bench for soc_ifc_fuse_wr_tracker (default or SOC_IFC_FUSE_WR_STRICT_EN build).
module tb_soc_ifc_fuse_wr_tracker;

    logic       clk = 1'b0;
    logic       cptra_rst;
    logic       ready_for_fuses;
    logic       fuse_done_reg;
    logic       fuse_done_set;
    logic       fuse_wr_done_observed;
    logic       fuse_wr_err;
    logic [6:0] fuse_wr_count;

    int errors = 0;
    int checks = 0;

    soc_ifc_fuse_wr_tracker_if #(.ADDR_W(8)) bus ();

    soc_ifc_fuse_wr_tracker #(
        .NUM_FUSE_WORDS(64),
        .ADDR_W(8),
        .FUSE_DONE_ADDR(64)
    ) dut (
        .clk                   (clk),
        .cptra_rst             (cptra_rst),
        .ready_for_fuses       (ready_for_fuses),
        .fuse_done_reg         (fuse_done_reg),
        .bus                   (bus),
        .fuse_done_set         (fuse_done_set),
        .fuse_wr_done_observed (fuse_wr_done_observed),
        .fuse_wr_err           (fuse_wr_err),
        .fuse_wr_count         (fuse_wr_count)
    );

    always #5 clk = ~clk;

    // Pulses must never overlap.
    always @(negedge clk) begin
        if (!cptra_rst) begin
            checks++;
            if ($countones({bus.fuse_we, fuse_done_set, fuse_wr_err}) > 1) begin
                errors++;
                $display("FAIL excl: we/set/err=%b, required at most one set",
                         {bus.fuse_we, fuse_done_set, fuse_wr_err});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Request held across one posedge; outputs are observed at the following negedge.
    task automatic req(input logic [7:0] a, input logic [31:0] d);
        bus.soc_req_vld   = 1'b1;
        bus.soc_req_addr  = a;
        bus.soc_req_wdata = d;
        @(negedge clk);
        bus.soc_req_vld   = 1'b0;
    endtask

    task automatic do_reset();
        cptra_rst = 1'b1;
        idle(2);
        cptra_rst = 1'b0;
    endtask

    task automatic test_reset();
        ready_for_fuses = 1'b1;
        fuse_done_reg   = 1'b0;
        do_reset();
        checks++;
        if ({bus.fuse_we, fuse_done_set, fuse_wr_err, fuse_wr_done_observed, fuse_wr_count} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outs: got we/set/err/obs/cnt=%b/%b/%b/%b/%0d, required all 0",
                     bus.fuse_we, fuse_done_set, fuse_wr_err, fuse_wr_done_observed, fuse_wr_count);
        end
        checks++;
        if ({bus.fuse_wr_addr, bus.fuse_wr_data} !== 40'd0) begin
            errors++;
            $display("FAIL reset_wr_bus: got addr=%0d data=%h, required 0/0", bus.fuse_wr_addr, bus.fuse_wr_data);
        end
        idle(1);
        req(8'd9, 32'h1234);
        checks++;
        if (bus.fuse_we !== 1'b1 || fuse_wr_count !== 7'd1) begin
            errors++;
            $display("FAIL pre_mid_reset: got we=%b cnt=%0d, required 1/1", bus.fuse_we, fuse_wr_count);
        end
        cptra_rst = 1'b1;
        req(8'd10, 32'h5678);
        cptra_rst = 1'b0;
        checks++;
        if ({bus.fuse_we, fuse_wr_err, fuse_wr_count, bus.fuse_wr_addr} !== 17'd0) begin
            errors++;
            $display("FAIL mid_reset_discard: got we=%b err=%b cnt=%0d addr=%0d, required all 0",
                     bus.fuse_we, fuse_wr_err, fuse_wr_count, bus.fuse_wr_addr);
        end
    endtask

    task automatic test_cold_boot();
        ready_for_fuses = 1'b1;
        fuse_done_reg   = 1'b0;
        do_reset();
        idle(1);
        for (int i = 0; i < 64; i++) begin
            req(8'(i), 32'(i));
            checks++;
            if (bus.fuse_we !== 1'b1 || bus.fuse_wr_addr !== 8'(i) || bus.fuse_wr_data !== 32'(i)
                || fuse_wr_count !== 7'(i + 1)) begin
                errors++;
                $display("FAIL cold_wr[%0d]: got we=%b addr=%0d data=%0d cnt=%0d, required 1/%0d/%0d/%0d",
                         i, bus.fuse_we, bus.fuse_wr_addr, bus.fuse_wr_data, fuse_wr_count, i, i, i + 1);
            end
        end
        req(8'd64, 32'h1);
        checks++;
        if ({bus.fuse_we, fuse_done_set, fuse_wr_err, fuse_wr_done_observed} !== 4'b0101) begin
            errors++;
            $display("FAIL cold_done: got we/set/err/obs=%b, required 0101",
                     {bus.fuse_we, fuse_done_set, fuse_wr_err, fuse_wr_done_observed});
        end
        idle(1);
        checks++;
        if (fuse_done_set !== 1'b0 || fuse_wr_done_observed !== 1'b1) begin
            errors++;
            $display("FAIL cold_set_pulse: got set=%b obs=%b, required 0/1", fuse_done_set, fuse_wr_done_observed);
        end
        req(8'd5, 32'hdead);
        checks++;
        if ({bus.fuse_we, fuse_wr_err} !== 2'b01 || fuse_wr_count !== 7'd64 || bus.fuse_wr_addr !== 8'd63) begin
            errors++;
            $display("FAIL locked_wr: got we=%b err=%b cnt=%0d addr=%0d, required 0/1/64/63",
                     bus.fuse_we, fuse_wr_err, fuse_wr_count, bus.fuse_wr_addr);
        end
    endtask

    task automatic test_warm_reentry();
        ready_for_fuses = 1'b1;
        fuse_done_reg   = 1'b1;
        do_reset();
        checks++;
        if (fuse_wr_done_observed !== 1'b0) begin
            errors++;
            $display("FAIL warm_obs_reset: got %b, required 0", fuse_wr_done_observed);
        end
        idle(1);
        req(8'd3, 32'h3);
        checks++;
        if ({bus.fuse_we, fuse_wr_err} !== 2'b01) begin
            errors++;
            $display("FAIL warm_wr: got we/err=%b, required 01", {bus.fuse_we, fuse_wr_err});
        end
        req(8'd64, 32'h1);
        checks++;
        if ({fuse_done_set, fuse_wr_err, fuse_wr_done_observed} !== 3'b001) begin
            errors++;
            $display("FAIL warm_done: got set/err/obs=%b, required 001",
                     {fuse_done_set, fuse_wr_err, fuse_wr_done_observed});
        end
        req(8'd64, 32'h0);
        checks++;
        if ({fuse_done_set, fuse_wr_err, fuse_wr_done_observed} !== 3'b001) begin
            errors++;
            $display("FAIL warm_done0: got set/err/obs=%b, required 001",
                     {fuse_done_set, fuse_wr_err, fuse_wr_done_observed});
        end
    endtask

    task automatic test_open();
        ready_for_fuses = 1'b1;
        fuse_done_reg   = 1'b0;
        do_reset();
        idle(1);
        req(8'd7, 32'hAAAA_0007);
        checks++;
        if (bus.fuse_we !== 1'b1 || bus.fuse_wr_data !== 32'hAAAA_0007 || fuse_wr_count !== 7'd1) begin
            errors++;
            $display("FAIL open_wr7a: got we=%b data=%h cnt=%0d, required 1/aaaa0007/1",
                     bus.fuse_we, bus.fuse_wr_data, fuse_wr_count);
        end
        req(8'd7, 32'hBBBB_0007);
        checks++;
        if (bus.fuse_we !== 1'b1 || bus.fuse_wr_data !== 32'hBBBB_0007 || fuse_wr_count !== 7'd1) begin
            errors++;
            $display("FAIL open_wr7b: got we=%b data=%h cnt=%0d, required 1/bbbb0007/1",
                     bus.fuse_we, bus.fuse_wr_data, fuse_wr_count);
        end
        req(8'd64, 32'h0);
        checks++;
        if ({bus.fuse_we, fuse_done_set, fuse_wr_err, fuse_wr_done_observed} !== 4'b0000) begin
            errors++;
            $display("FAIL open_done0: got we/set/err/obs=%b, required 0000",
                     {bus.fuse_we, fuse_done_set, fuse_wr_err, fuse_wr_done_observed});
        end
        req(8'd200, 32'h1);
        checks++;
        if ({bus.fuse_we, fuse_wr_err} !== 2'b01) begin
            errors++;
            $display("FAIL open_addr200: got we/err=%b, required 01", {bus.fuse_we, fuse_wr_err});
        end
        req(8'd65, 32'h1);
        checks++;
        if ({bus.fuse_we, fuse_done_set, fuse_wr_err} !== 3'b001) begin
            errors++;
            $display("FAIL open_addr65: got we/set/err=%b, required 001", {bus.fuse_we, fuse_done_set, fuse_wr_err});
        end
        req(8'd63, 32'h63);
        checks++;
        if (bus.fuse_we !== 1'b1 || bus.fuse_wr_addr !== 8'd63 || fuse_wr_count !== 7'd2) begin
            errors++;
            $display("FAIL open_wr63: got we=%b addr=%0d cnt=%0d, required 1/63/2",
                     bus.fuse_we, bus.fuse_wr_addr, fuse_wr_count);
        end
        req(8'd64, 32'h1);
        checks++;
`ifdef SOC_IFC_FUSE_WR_STRICT_EN
        if ({fuse_done_set, fuse_wr_err, fuse_wr_done_observed} !== 3'b010) begin
            errors++;
            $display("FAIL open_done_partial: got set/err/obs=%b, required 010",
                     {fuse_done_set, fuse_wr_err, fuse_wr_done_observed});
        end
`else
        if ({fuse_done_set, fuse_wr_err, fuse_wr_done_observed} !== 3'b101) begin
            errors++;
            $display("FAIL open_done_partial: got set/err/obs=%b, required 101",
                     {fuse_done_set, fuse_wr_err, fuse_wr_done_observed});
        end
`endif
    endtask

    task automatic test_ready_gating();
        ready_for_fuses = 1'b0;
        fuse_done_reg   = 1'b0;
        do_reset();
        idle(1);
        req(8'd0, 32'h0);
        checks++;
        if ({bus.fuse_we, fuse_wr_err} !== 2'b01) begin
            errors++;
            $display("FAIL wait_wr0: got we/err=%b, required 01", {bus.fuse_we, fuse_wr_err});
        end
        ready_for_fuses = 1'b1;
        req(8'd1, 32'h11);
        checks++;
        if ({bus.fuse_we, fuse_wr_err} !== 2'b01) begin
            errors++;
            $display("FAIL same_cycle_ready: got we/err=%b, required 01", {bus.fuse_we, fuse_wr_err});
        end
        req(8'd1, 32'h11);
        checks++;
        if ({bus.fuse_we, fuse_wr_err} !== 2'b10 || fuse_wr_count !== 7'd1) begin
            errors++;
            $display("FAIL after_ready_wr1: got we/err=%b cnt=%0d, required 10/1", {bus.fuse_we, fuse_wr_err}, fuse_wr_count);
        end
        ready_for_fuses = 1'b0;
        req(8'd2, 32'h22);
        checks++;
        if ({bus.fuse_we, fuse_wr_err} !== 2'b10 || fuse_wr_count !== 7'd2) begin
            errors++;
            $display("FAIL ready_fall_wr2: got we/err=%b cnt=%0d, required 10/2", {bus.fuse_we, fuse_wr_err}, fuse_wr_count);
        end
        req(8'd3, 32'h33);
        checks++;
        if ({bus.fuse_we, fuse_wr_err} !== 2'b01 || fuse_wr_count !== 7'd2) begin
            errors++;
            $display("FAIL reclosed_wr3: got we/err=%b cnt=%0d, required 01/2", {bus.fuse_we, fuse_wr_err}, fuse_wr_count);
        end
        ready_for_fuses = 1'b1;
        idle(1);
        req(8'd2, 32'h22);
        checks++;
        if ({bus.fuse_we, fuse_wr_err} !== 2'b10 || fuse_wr_count !== 7'd2) begin
            errors++;
            $display("FAIL reopen_rewr2: got we/err=%b cnt=%0d, required 10/2", {bus.fuse_we, fuse_wr_err}, fuse_wr_count);
        end
        req(8'd3, 32'h33);
        checks++;
        if ({bus.fuse_we, fuse_wr_err} !== 2'b10 || fuse_wr_count !== 7'd3) begin
            errors++;
            $display("FAIL reopen_wr3: got we/err=%b cnt=%0d, required 10/3", {bus.fuse_we, fuse_wr_err}, fuse_wr_count);
        end
    endtask

    task automatic test_strict();
        ready_for_fuses = 1'b1;
        fuse_done_reg   = 1'b0;
        do_reset();
        idle(1);
        for (int i = 0; i < 63; i++) req(8'(i), ~32'(i));
        checks++;
        if (fuse_wr_count !== 7'd63) begin
            errors++;
            $display("FAIL strict_cnt63: got %0d, required 63", fuse_wr_count);
        end
        req(8'd64, 32'h1);
        checks++;
`ifdef SOC_IFC_FUSE_WR_STRICT_EN
        if ({fuse_done_set, fuse_wr_err, fuse_wr_done_observed} !== 3'b010) begin
            errors++;
            $display("FAIL strict_done_63: got set/err/obs=%b, required 010",
                     {fuse_done_set, fuse_wr_err, fuse_wr_done_observed});
        end
        req(8'd63, 32'h63);
        checks++;
        if (bus.fuse_we !== 1'b1 || fuse_wr_count !== 7'd64) begin
            errors++;
            $display("FAIL strict_wr63: got we=%b cnt=%0d, required 1/64", bus.fuse_we, fuse_wr_count);
        end
        req(8'd64, 32'h1);
        checks++;
        if ({fuse_done_set, fuse_wr_err, fuse_wr_done_observed} !== 3'b101) begin
            errors++;
            $display("FAIL strict_done_64: got set/err/obs=%b, required 101",
                     {fuse_done_set, fuse_wr_err, fuse_wr_done_observed});
        end
`else
        if ({fuse_done_set, fuse_wr_err, fuse_wr_done_observed} !== 3'b101) begin
            errors++;
            $display("FAIL loose_done_63: got set/err/obs=%b, required 101",
                     {fuse_done_set, fuse_wr_err, fuse_wr_done_observed});
        end
        req(8'd63, 32'h63);
        checks++;
        if ({bus.fuse_we, fuse_wr_err} !== 2'b01 || fuse_wr_count !== 7'd63) begin
            errors++;
            $display("FAIL loose_wr63_locked: got we/err=%b cnt=%0d, required 01/63",
                     {bus.fuse_we, fuse_wr_err}, fuse_wr_count);
        end
`endif
    endtask

    initial begin
        cptra_rst         = 1'b1;
        ready_for_fuses   = 1'b0;
        fuse_done_reg     = 1'b0;
        bus.soc_req_vld   = 1'b0;
        bus.soc_req_addr  = '0;
        bus.soc_req_wdata = '0;
        idle(1);
        test_reset();
        test_cold_boot();
        test_warm_reentry();
        test_open();
        test_ready_gating();
        test_strict();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
